// File: rtl/sdr_port_arbiter.sv
// Round-robin arbiter sharing one avalon_sdr engine between the ray-fetch reader
// and the result writer, with a per-transfer watchdog.
module sdr_port_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int WDATA_W = 224,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_grant,
  output logic               rd_done,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WDATA_W-1:0] wr_data,
  output logic               wr_grant,
  output logic               wr_done,
  output logic               op_err,
  output logic               timeout_err,
  output logic               busy,
  output logic               sdr_readstart,
  output logic               sdr_writestart,
  output logic [ADDR_W-1:0]  sdr_addr,
  output logic [WDATA_W-1:0] sdr_writedata,
  input  logic               sdr_readend,
  input  logic               sdr_writeend
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    RD_START,
    RD_WAIT,
    WR_START,
    WR_WAIT
  } state_t;

  state_t           state, state_d;
  logic             last_wr;
  logic [CNT_W-1:0] wdog;
  logic             grant_rd, grant_wr;
  logic             fin, expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // End strobe takes priority over watchdog expiry on the same edge.
  always_comb begin
    state_d  = state;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    fin      = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req && (!wr_req || last_wr)) begin
          grant_rd = 1'b1;
          state_d  = RD_START;
        end else if (wr_req) begin
          grant_wr = 1'b1;
          state_d  = WR_START;
        end
      end
      RD_START: state_d = RD_WAIT;
      WR_START: state_d = WR_WAIT;
      RD_WAIT: begin
        if (sdr_readend)            fin    = 1'b1;
        else if (wdog == CNT_LIMIT) expire = 1'b1;
        if (sdr_readend || wdog == CNT_LIMIT) state_d = IDLE;
      end
      WR_WAIT: begin
        if (sdr_writeend)           fin    = 1'b1;
        else if (wdog == CNT_LIMIT) expire = 1'b1;
        if (sdr_writeend || wdog == CNT_LIMIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdr_readstart  = (state == RD_START);
  assign sdr_writestart = (state == WR_START);
  assign rd_grant       = (state == RD_START);
  assign wr_grant       = (state == WR_START);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_wr       <= 1'b1;
      wdog          <= '0;
      rd_done       <= 1'b0;
      wr_done       <= 1'b0;
      op_err        <= 1'b0;
      timeout_err   <= 1'b0;
      sdr_addr      <= '0;
      sdr_writedata <= '0;
    end else begin
      rd_done <= (state == RD_WAIT) && (fin || expire);
      wr_done <= (state == WR_WAIT) && (fin || expire);
      op_err  <= expire;
      if (expire) timeout_err <= 1'b1;

      // Engine-side address/payload only move on a grant edge.
      if (grant_rd) begin
        sdr_addr <= rd_addr;
        last_wr  <= 1'b0;
      end
      if (grant_wr) begin
        sdr_addr      <= wr_addr;
        sdr_writedata <= wr_data;
        last_wr       <= 1'b1;
      end

      if (state == RD_START || state == WR_START)
        wdog <= '0;
      else if ((state == RD_WAIT || state == WR_WAIT) && wdog != '1)
        wdog <= wdog + 1'b1;
    end
  end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Directed bench for sdr_port_arbiter: one default-timeout instance and one with
// TIMEOUT = 8, both driven from the same stimulus.
module tb_sdr_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 224;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          sdr_readend = 1'b0, sdr_writeend = 1'b0;

  logic          rd_grant, rd_done, wr_grant, wr_done, op_err, timeout_err, busy;
  logic          sdr_readstart, sdr_writestart;
  logic [AW-1:0] sdr_addr;
  logic [DW-1:0] sdr_writedata;

  logic          rd_grant8, rd_done8, wr_grant8, wr_done8, op_err8, timeout_err8, busy8;
  logic          sdr_readstart8, sdr_writestart8;
  logic [AW-1:0] sdr_addr8;
  logic [DW-1:0] sdr_writedata8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdr_port_arbiter #(.ADDR_W(AW), .WDATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
    .wr_done(wr_done), .op_err(op_err), .timeout_err(timeout_err), .busy(busy),
    .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
    .sdr_addr(sdr_addr), .sdr_writedata(sdr_writedata),
    .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend)
  );

  sdr_port_arbiter #(.ADDR_W(AW), .WDATA_W(DW), .TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant8), .rd_done(rd_done8),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant8),
    .wr_done(wr_done8), .op_err(op_err8), .timeout_err(timeout_err8), .busy(busy8),
    .sdr_readstart(sdr_readstart8), .sdr_writestart(sdr_writestart8),
    .sdr_addr(sdr_addr8), .sdr_writedata(sdr_writedata8),
    .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"},   busy, 1'b0);
    chk({tag, ".rgnt"},   rd_grant, 1'b0);
    chk({tag, ".wgnt"},   wr_grant, 1'b0);
    chk({tag, ".rdone"},  rd_done, 1'b0);
    chk({tag, ".wdone"},  wr_done, 1'b0);
    chk({tag, ".operr"},  op_err, 1'b0);
    chk({tag, ".toerr"},  timeout_err, 1'b0);
    chk({tag, ".rstart"}, sdr_readstart, 1'b0);
    chk({tag, ".wstart"}, sdr_writestart, 1'b0);
    chk({tag, ".addr"},   sdr_addr, '0);
    chk({tag, ".wdata"},  sdr_writedata, '0);
  endtask

  initial begin
    // Reset state, then write interrupted by reset
    #12;
    chk_quiet("rst0");
    #8 reset = 1'b1;
    tick();
    wr_req  = 1'b1;
    wr_addr = 25'h0000100;
    wr_data = {7{32'hDEADBEEF}};
    tick();
    chk("t1.wstart", sdr_writestart, 1'b1);
    chk("t1.wgnt",   wr_grant, 1'b1);
    chk("t1.rstart", sdr_readstart, 1'b0);
    chk("t1.addr",   sdr_addr, 25'h0000100);
    chk("t1.wdata",  sdr_writedata, {7{32'hDEADBEEF}});
    wr_req = 1'b0;
    tick();
    chk("t1.wstart_w", sdr_writestart, 1'b0);
    chk("t1.busy_w",   busy, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    chk_quiet("t1.rst");
    tick();
    chk("t1.nodone", wr_done, 1'b0);
    reset = 1'b1;
    tick();
    chk("t1.nodone2", wr_done, 1'b0);

    // Single read, readend 10 cycles after start
    rd_req  = 1'b1;
    rd_addr = 25'h0000040;
    tick();
    chk("t2.rgnt",   rd_grant, 1'b1);
    chk("t2.rstart", sdr_readstart, 1'b1);
    chk("t2.addr",   sdr_addr, 25'h0000040);
    rd_req  = 1'b0;
    rd_addr = 25'h00003FF;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("t2.hold",  sdr_addr, 25'h0000040);
      chk("t2.early", rd_done, 1'b0);
      chk("t2.busy",  busy, 1'b1);
    end
    tick();
    sdr_readend = 1'b1;
    tick();
    sdr_readend = 1'b0;
    chk("t2.done",  rd_done, 1'b1);
    chk("t2.busy0", busy, 1'b0);
    chk("t2.operr", op_err, 1'b0);
    chk("t2.addr2", sdr_addr, 25'h0000040);
    tick();
    chk("t2.done1", rd_done, 1'b0);

    // Tie arbitration from a fresh reset: R, W, R, W with one idle cycle between
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    rd_addr = 25'h0000011;
    wr_addr = 25'h0000022;
    wr_data = {7{32'h12345678}};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3.rstart", sdr_readstart, (k % 2) == 0);
      chk("t3.wstart", sdr_writestart, (k % 2) == 1);
      chk("t3.addr",   sdr_addr, ((k % 2) == 0) ? 25'h0000011 : 25'h0000022);
      tick();
      tick();
      tick();
      if ((k % 2) == 0) sdr_readend = 1'b1;
      else              sdr_writeend = 1'b1;
      tick();
      sdr_readend  = 1'b0;
      sdr_writeend = 1'b0;
      chk("t3.rdone", rd_done, (k % 2) == 0);
      chk("t3.wdone", wr_done, (k % 2) == 1);
      chk("t3.idle",  busy, 1'b0);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();
    chk("t3.quiet", busy, 1'b0);

    // Wrong strobe during a read is ignored
    rd_req  = 1'b1;
    rd_addr = 25'h0000080;
    tick();
    chk("t4.rstart", sdr_readstart, 1'b1);
    rd_req = 1'b0;
    tick();
    sdr_writeend = 1'b1;
    tick();
    sdr_writeend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4.busy",  busy, 1'b1);
      chk("t4.rdone", rd_done, 1'b0);
      chk("t4.wdone", wr_done, 1'b0);
      tick();
    end
    sdr_readend = 1'b1;
    tick();
    sdr_readend = 1'b0;
    chk("t4.done",  rd_done, 1'b1);
    chk("t4.wdone1", wr_done, 1'b0);
    chk("t4.operr", op_err, 1'b0);

    // Watchdog on the TIMEOUT = 8 instance
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 25'h0000200;
    wr_data = {7{32'hCAFEF00D}};
    tick();
    chk("t5.wstart", sdr_writestart8, 1'b1);
    wr_req = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("t5.busy",  busy8, 1'b1);
      chk("t5.early", wr_done8, 1'b0);
      chk("t5.noerr", timeout_err8, 1'b0);
    end
    tick();
    chk("t5.done",   wr_done8, 1'b1);
    chk("t5.operr",  op_err8, 1'b1);
    chk("t5.toerr",  timeout_err8, 1'b1);
    chk("t5.idle",   busy8, 1'b0);
    chk("t5.rdone",  rd_done8, 1'b0);
    chk("t5.wdata",  sdr_writedata8, {7{32'hCAFEF00D}});
    tick();
    chk("t5.operr1", op_err8, 1'b0);
    chk("t5.sticky", timeout_err8, 1'b1);
    rd_req  = 1'b1;
    rd_addr = 25'h0000033;
    tick();
    chk("t5.rstart", sdr_readstart8, 1'b1);
    rd_req = 1'b0;
    tick();
    sdr_readend = 1'b1;
    tick();
    sdr_readend = 1'b0;
    chk("t5.gdone",   rd_done8, 1'b1);
    chk("t5.gopok",   op_err8, 1'b0);
    chk("t5.sticky2", timeout_err8, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5.clr", timeout_err8, 1'b0);
    tick();
    reset = 1'b1;

    // readend exactly on the expiry edge
    rd_req  = 1'b1;
    rd_addr = 25'h0000055;
    tick();
    chk("t6.rstart", sdr_readstart8, 1'b1);
    rd_req = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("t6.busy", busy8, 1'b1);
      chk("t6.early", rd_done8, 1'b0);
    end
    sdr_readend = 1'b1;
    tick();
    sdr_readend = 1'b0;
    chk("t6.done",  rd_done8, 1'b1);
    chk("t6.operr", op_err8, 1'b0);
    chk("t6.toerr", timeout_err8, 1'b0);
    chk("t6.idle",  busy8, 1'b0);
    tick();
    chk("t6.toerr1", timeout_err8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
